// File: rtl/id_ex_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_stage_if
// Bundle of the ID-side inputs and EX-side outputs of the ID/EX pipeline
// register. The slave modport is the register itself. The master modport is
// the surrounding pipeline, or a testbench.
//
// Build option: IDEX_STALL_COUNT_EN adds the StallCount output.
//
// Signals (direction as seen by the slave):
//   in_Valid, in_Flush, in_Hold, in_UsesRt        in   control from ID / hazard
//   in_Ctrl[CTRL_W-1:0]                           in   decoded control bundle
//   in_IfId_RegisterRs/Rt/Rd[4:0]                 in   register numbers
//   in_ReadData1/2, in_SignExtImm, in_PC4         in   ID operands
//   IdEx_Valid, IdEx_Ctrl, IdEx_Register*         out  registered EX view
//   IdEx_ReadData1/2, IdEx_SignExtImm, IdEx_PC4   out  registered EX operands
//   Stall                                         out  load-use hazard
//   StallCount[31:0] (optional)                   out  stall-bubble counter
// -----------------------------------------------------------------------------
interface id_ex_stage_if #(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 3
);
  localparam int CTRL_W = 6 + ALUOP_W;

  logic              in_Valid;
  logic              in_Flush;
  logic              in_Hold;
  logic              in_UsesRt;
  logic [CTRL_W-1:0] in_Ctrl;
  logic [4:0]        in_IfId_RegisterRs;
  logic [4:0]        in_IfId_RegisterRt;
  logic [4:0]        in_IfId_RegisterRd;
  logic [DATA_W-1:0] in_ReadData1;
  logic [DATA_W-1:0] in_ReadData2;
  logic [DATA_W-1:0] in_SignExtImm;
  logic [DATA_W-1:0] in_PC4;

  logic              IdEx_Valid;
  logic [CTRL_W-1:0] IdEx_Ctrl;
  logic [4:0]        IdEx_RegisterRs;
  logic [4:0]        IdEx_RegisterRt;
  logic [4:0]        IdEx_RegisterRd;
  logic [DATA_W-1:0] IdEx_ReadData1;
  logic [DATA_W-1:0] IdEx_ReadData2;
  logic [DATA_W-1:0] IdEx_SignExtImm;
  logic [DATA_W-1:0] IdEx_PC4;
  logic              Stall;
`ifdef IDEX_STALL_COUNT_EN
  logic [31:0]       StallCount;
`endif

  modport slave (
    input  in_Valid, in_Flush, in_Hold, in_UsesRt, in_Ctrl,
           in_IfId_RegisterRs, in_IfId_RegisterRt, in_IfId_RegisterRd,
           in_ReadData1, in_ReadData2, in_SignExtImm, in_PC4,
    output IdEx_Valid, IdEx_Ctrl, IdEx_RegisterRs, IdEx_RegisterRt,
           IdEx_RegisterRd, IdEx_ReadData1, IdEx_ReadData2,
           IdEx_SignExtImm, IdEx_PC4, Stall
`ifdef IDEX_STALL_COUNT_EN
    , output StallCount
`endif
  );

  modport master (
    output in_Valid, in_Flush, in_Hold, in_UsesRt, in_Ctrl,
           in_IfId_RegisterRs, in_IfId_RegisterRt, in_IfId_RegisterRd,
           in_ReadData1, in_ReadData2, in_SignExtImm, in_PC4,
    input  IdEx_Valid, IdEx_Ctrl, IdEx_RegisterRs, IdEx_RegisterRt,
           IdEx_RegisterRd, IdEx_ReadData1, IdEx_ReadData2,
           IdEx_SignExtImm, IdEx_PC4, Stall
`ifdef IDEX_STALL_COUNT_EN
    , input StallCount
`endif
  );
endinterface

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register of the 5-stage MIPS core. It includes load-use
// hazard detection and bubble insertion.
//
// Ports:
//   clk    in   pipeline clock, rising edge
//   reset  in   synchronous, active-low
//   bus    id_ex_stage_if.slave
//          - ID-side operands and control
//          - EX-side registered outputs
//          - Stall
//
// Build option: IDEX_STALL_COUNT_EN adds bus.StallCount. This is a
// saturating count of bubbles inserted because of a load-use stall. Bubbles
// inserted because of a flush are not counted.
//
// Control bundle: [0] RegWrite, [1] MemRead, [2] MemWrite, [3] MemtoReg,
// [4] ALUSrc, [5] RegDst, [6+:ALUOP_W] ALUOp.
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 3
) (
  input  logic         clk,
  input  logic         reset,
  id_ex_stage_if.slave bus
);
  localparam int CTRL_W      = 6 + ALUOP_W;
  localparam int MEMREAD_BIT = 1;

  logic              valid_p1;
  logic [CTRL_W-1:0] ctrl_p1;
  logic [4:0]        rs_p1;
  logic [4:0]        rt_p1;
  logic [4:0]        rd_p1;
  logic [DATA_W-1:0] readData1_p1;
  logic [DATA_W-1:0] readData2_p1;
  logic [DATA_W-1:0] signExtImm_p1;
  logic [DATA_W-1:0] pc4_p1;

  logic hazard;
  logic stall;

  // ID stage: load-use detection against the instruction currently in EX.
  // A load result is not available for forwarding into the very next EX.
  // An ID instruction that needs that result therefore waits one cycle.
  // A squashed ID instruction must not stall the front end.
  always_comb begin
    hazard = valid_p1 & ctrl_p1[MEMREAD_BIT] & bus.in_Valid &
             (rt_p1 != 5'd0) &
             ((rt_p1 == bus.in_IfId_RegisterRs) |
              (bus.in_UsesRt & (rt_p1 == bus.in_IfId_RegisterRt)));
    stall  = hazard & ~bus.in_Flush;
  end

  // ID -> EX register boundary.
  // Priority: reset, flush bubble, hold, stall bubble, normal load.
  // A bubble also zeroes the register numbers and data. An empty slot can
  // then never satisfy a forwarding compare.
  always_ff @(posedge clk) begin
    if (!reset || bus.in_Flush || (!bus.in_Hold && stall)) begin
      valid_p1      <= 1'b0;
      ctrl_p1       <= '0;
      rs_p1         <= '0;
      rt_p1         <= '0;
      rd_p1         <= '0;
      readData1_p1  <= '0;
      readData2_p1  <= '0;
      signExtImm_p1 <= '0;
      pc4_p1        <= '0;
    end else if (!bus.in_Hold) begin
      valid_p1      <= bus.in_Valid;
      // An invalid slot carries no control, so no write can escape from it.
      ctrl_p1       <= bus.in_Valid ? bus.in_Ctrl : '0;
      rs_p1         <= bus.in_IfId_RegisterRs;
      rt_p1         <= bus.in_IfId_RegisterRt;
      rd_p1         <= bus.in_IfId_RegisterRd;
      readData1_p1  <= bus.in_ReadData1;
      readData2_p1  <= bus.in_ReadData2;
      signExtImm_p1 <= bus.in_SignExtImm;
      pc4_p1        <= bus.in_PC4;
    end
  end

`ifdef IDEX_STALL_COUNT_EN
  logic [31:0] stallCount_p1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stallCount_p1 <= '0;
    end else if (!bus.in_Hold && stall && (stallCount_p1 != 32'hFFFF_FFFF)) begin
      stallCount_p1 <= stallCount_p1 + 32'd1;
    end
  end

  assign bus.StallCount = stallCount_p1;
`endif

  assign bus.IdEx_Valid      = valid_p1;
  assign bus.IdEx_Ctrl       = ctrl_p1;
  assign bus.IdEx_RegisterRs = rs_p1;
  assign bus.IdEx_RegisterRt = rt_p1;
  assign bus.IdEx_RegisterRd = rd_p1;
  assign bus.IdEx_ReadData1  = readData1_p1;
  assign bus.IdEx_ReadData2  = readData2_p1;
  assign bus.IdEx_SignExtImm = signExtImm_p1;
  assign bus.IdEx_PC4        = pc4_p1;
  assign bus.Stall           = stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed testbench for id_ex_stage. The expected values are worked out by
// hand for each instruction sequence.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;
  localparam int DATA_W  = 32;
  localparam int ALUOP_W = 3;
  localparam int CTRL_W  = 6 + ALUOP_W;

  // lw: RegWrite|MemRead|MemtoReg|ALUSrc
  localparam logic [CTRL_W-1:0] CTRL_LW  = 9'h01B;
  // add: RegWrite|RegDst, ALUOp=2
  localparam logic [CTRL_W-1:0] CTRL_ADD = 9'h0A1;

  logic clk = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;

  id_ex_stage_if #(.DATA_W(DATA_W), .ALUOP_W(ALUOP_W)) bus ();

  id_ex_stage #(.DATA_W(DATA_W), .ALUOP_W(ALUOP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] obs,
                          input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one ID-stage instruction. The remaining operands are derived from
  // rd1, so each field holds a value that can be told apart from the others.
  task automatic setId(input logic v, input logic [CTRL_W-1:0] c,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic usesRt,
                       input logic [DATA_W-1:0] rd1);
    bus.in_Valid           = v;
    bus.in_Ctrl            = c;
    bus.in_IfId_RegisterRs = rs;
    bus.in_IfId_RegisterRt = rt;
    bus.in_IfId_RegisterRd = rd;
    bus.in_UsesRt          = usesRt;
    bus.in_ReadData1       = rd1;
    bus.in_ReadData2       = rd1 + 32'h1;
    bus.in_SignExtImm      = rd1 + 32'h2;
    bus.in_PC4             = rd1 + 32'h4;
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    bus.in_Flush = 1'b0;
    bus.in_Hold  = 1'b0;
    setId(1'b1, CTRL_LW, 5'd3, 5'd8, 5'd0, 1'b0, 32'h0000_0100);

    // Reset with non-zero inputs present
    tick();
    tick();
    checkVal("rst_valid", bus.IdEx_Valid, 0);
    checkVal("rst_ctrl",  bus.IdEx_Ctrl, 0);
    checkVal("rst_rt",    bus.IdEx_RegisterRt, 0);
    checkVal("rst_rd1",   bus.IdEx_ReadData1, 0);
    checkVal("rst_pc4",   bus.IdEx_PC4, 0);
    checkVal("rst_stall", bus.Stall, 0);
`ifdef IDEX_STALL_COUNT_EN
    checkVal("rst_cnt",   bus.StallCount, 0);
`endif

    // First edge after release loads lw $8
    reset = 1'b1;
    tick();
    checkVal("ld_valid", bus.IdEx_Valid, 1);
    checkVal("ld_ctrl",  bus.IdEx_Ctrl, CTRL_LW);
    checkVal("ld_rt",    bus.IdEx_RegisterRt, 8);
    checkVal("ld_rs",    bus.IdEx_RegisterRs, 3);
    checkVal("ld_rd1",   bus.IdEx_ReadData1, 32'h100);
    checkVal("ld_rd2",   bus.IdEx_ReadData2, 32'h101);
    checkVal("ld_imm",   bus.IdEx_SignExtImm, 32'h102);
    checkVal("ld_pc4",   bus.IdEx_PC4, 32'h104);

    // Load-use: add $10,$8,$5 in ID
    setId(1'b1, CTRL_ADD, 5'd8, 5'd5, 5'd10, 1'b1, 32'h0000_0200);
    checkVal("lu_stall", bus.Stall, 1);
    tick();
    checkVal("lu_bub_valid", bus.IdEx_Valid, 0);
    checkVal("lu_bub_ctrl",  bus.IdEx_Ctrl, 0);
    checkVal("lu_bub_rs",    bus.IdEx_RegisterRs, 0);
    checkVal("lu_bub_rd1",   bus.IdEx_ReadData1, 0);
    checkVal("lu_stall_drop", bus.Stall, 0);
`ifdef IDEX_STALL_COUNT_EN
    checkVal("lu_cnt", bus.StallCount, 1);
`endif
    tick();
    checkVal("lu_add_valid", bus.IdEx_Valid, 1);
    checkVal("lu_add_ctrl",  bus.IdEx_Ctrl, CTRL_ADD);
    checkVal("lu_add_rs",    bus.IdEx_RegisterRs, 8);
    checkVal("lu_add_rd",    bus.IdEx_RegisterRd, 10);

    // Rt-only dependency: lw $9 in EX
    setId(1'b1, CTRL_LW, 5'd4, 5'd9, 5'd0, 1'b0, 32'h0000_0300);
    tick();
    setId(1'b1, CTRL_LW, 5'd1, 5'd9, 5'd0, 1'b0, 32'h0000_0400);
    checkVal("rt_nouse_stall", bus.Stall, 0);
    setId(1'b1, CTRL_LW, 5'd1, 5'd9, 5'd0, 1'b1, 32'h0000_0400);
    checkVal("rt_use_stall", bus.Stall, 1);
    // Back-to-back independent loads load normally
    setId(1'b1, CTRL_LW, 5'd1, 5'd9, 5'd0, 1'b0, 32'h0000_0400);
    tick();
    checkVal("b2b_valid", bus.IdEx_Valid, 1);
    checkVal("b2b_rs",    bus.IdEx_RegisterRs, 1);
    checkVal("b2b_ctrl",  bus.IdEx_Ctrl, CTRL_LW);

    // Rt zero: lw $0 in EX, ID reads $0
    setId(1'b1, CTRL_LW, 5'd2, 5'd0, 5'd0, 1'b0, 32'h0000_0500);
    tick();
    setId(1'b1, CTRL_ADD, 5'd0, 5'd0, 5'd11, 1'b1, 32'h0000_0600);
    checkVal("rz_stall", bus.Stall, 0);
    tick();
    checkVal("rz_valid", bus.IdEx_Valid, 1);
    checkVal("rz_ctrl",  bus.IdEx_Ctrl, CTRL_ADD);
    checkVal("rz_rd",    bus.IdEx_RegisterRd, 11);

    // Flush beats stall: lw $7 in EX, dependent add in ID squashed
    setId(1'b1, CTRL_LW, 5'd1, 5'd7, 5'd0, 1'b0, 32'h0000_0700);
    tick();
    setId(1'b1, CTRL_ADD, 5'd7, 5'd5, 5'd12, 1'b1, 32'h0000_0800);
    checkVal("fl_hz_stall", bus.Stall, 1);
    bus.in_Flush = 1'b1;
    #1;
    checkVal("fl_stall", bus.Stall, 0);
    tick();
    bus.in_Flush = 1'b0;
    checkVal("fl_valid", bus.IdEx_Valid, 0);
    checkVal("fl_ctrl",  bus.IdEx_Ctrl, 0);
    checkVal("fl_rd1",   bus.IdEx_ReadData1, 0);
`ifdef IDEX_STALL_COUNT_EN
    checkVal("fl_cnt", bus.StallCount, 1);
`endif

    // Hold during hazard: lw $6 in EX, dependent add held for 3 cycles
    setId(1'b1, CTRL_LW, 5'd1, 5'd6, 5'd0, 1'b0, 32'h0000_0900);
    tick();
    setId(1'b1, CTRL_ADD, 5'd6, 5'd5, 5'd13, 1'b1, 32'h0000_0A00);
    bus.in_Hold = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkVal("hd_valid", bus.IdEx_Valid, 1);
      checkVal("hd_ctrl",  bus.IdEx_Ctrl, CTRL_LW);
      checkVal("hd_rt",    bus.IdEx_RegisterRt, 6);
      checkVal("hd_rd1",   bus.IdEx_ReadData1, 32'h900);
      checkVal("hd_stall", bus.Stall, 1);
`ifdef IDEX_STALL_COUNT_EN
      checkVal("hd_cnt", bus.StallCount, 1);
`endif
    end
    bus.in_Hold = 1'b0;
    tick();
    checkVal("hr_valid", bus.IdEx_Valid, 0);
    checkVal("hr_ctrl",  bus.IdEx_Ctrl, 0);
    checkVal("hr_stall", bus.Stall, 0);
`ifdef IDEX_STALL_COUNT_EN
    checkVal("hr_cnt", bus.StallCount, 2);
`endif
    tick();
    checkVal("hr_add_valid", bus.IdEx_Valid, 1);
    checkVal("hr_add_rs",    bus.IdEx_RegisterRs, 6);

    // Invalid slot: control forced to 0, data still loads
    setId(1'b0, CTRL_ADD, 5'd14, 5'd15, 5'd16, 1'b1, 32'h0000_0B00);
    tick();
    checkVal("iv_valid", bus.IdEx_Valid, 0);
    checkVal("iv_ctrl",  bus.IdEx_Ctrl, 0);
    checkVal("iv_rd1",   bus.IdEx_ReadData1, 32'hB00);
    checkVal("iv_rs",    bus.IdEx_RegisterRs, 14);

    // Reset while stalled discards the bubble
    setId(1'b1, CTRL_LW, 5'd1, 5'd8, 5'd0, 1'b0, 32'h0000_0C00);
    tick();
    setId(1'b1, CTRL_ADD, 5'd8, 5'd5, 5'd17, 1'b1, 32'h0000_0D00);
    checkVal("rs_hz_stall", bus.Stall, 1);
    reset = 1'b0;
    tick();
    checkVal("rs_valid", bus.IdEx_Valid, 0);
    checkVal("rs_stall", bus.Stall, 0);
`ifdef IDEX_STALL_COUNT_EN
    checkVal("rs_cnt", bus.StallCount, 0);
`endif
    reset = 1'b1;
    tick();
    checkVal("rs_add_valid", bus.IdEx_Valid, 1);
    checkVal("rs_add_ctrl",  bus.IdEx_Ctrl, CTRL_ADD);
    checkVal("rs_add_rd",    bus.IdEx_RegisterRd, 17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
